// File: rtl/credit_bp_tx_arb.sv
// Credit-based NoC link transmitter: one credit counter per virtual channel and a
// round-robin arbiter selecting one eligible VC per cycle onto the shared link.
module credit_bp_tx_arb #(
   parameter int NUM_VC  = 2,
   parameter int D_W     = 32,
   parameter int A_W     = 4,
   parameter int DEPTH   = 8,
   parameter int REG_OUT = 0,
   localparam int P_W    = A_W + D_W + 1,
   localparam int CW     = $clog2(DEPTH),
   localparam int PW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_VC-1:0]       i_v,
   input  logic [NUM_VC*P_W-1:0]   i_d,
   output logic [NUM_VC-1:0]       o_b,
   output logic [NUM_VC-1:0]       o_vc_target,
   output logic [P_W-1:0]          o_d,
   input  logic [NUM_VC-1:0]       i_vc_credit_gnt,
   output logic [NUM_VC-1:0]       o_credit_err
);

   localparam logic [CW-1:0] MAX_CR = CW'(DEPTH - 1);

   logic [CW-1:0]     cnt [NUM_VC];
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     ptr_nxt;
   logic [NUM_VC-1:0] has_cr;
   logic [NUM_VC-1:0] elig;
   logic [NUM_VC-1:0] rdy;
   logic [NUM_VC-1:0] win;
   logic [P_W-1:0]    sel_d;

   // Position of VC u in the round-robin search order that starts at pointer p.
   function automatic int rr_dist(input int u, input int p);
      return (u >= p) ? (u - p) : (u + NUM_VC - p);
   endfunction

   always_comb begin
      for (int v = 0; v < NUM_VC; v++) has_cr[v] = (cnt[v] != '0);
   end

   assign elig = i_v & has_cr;

   // Handshake: a packet on VC v transfers in any cycle where i_v[v] is high and
   // o_b[v] is low. o_b[v] is low exactly when VC v has a credit and no eligible
   // VC precedes it in round-robin order, so an idle VC sees the grant it would get.
   always_comb begin
      rdy = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         logic ahead;
         ahead = 1'b0;
         for (int u = 0; u < NUM_VC; u++) begin
            if (u != v && elig[u] && rr_dist(u, int'(ptr)) < rr_dist(v, int'(ptr)))
               ahead = 1'b1;
         end
         rdy[v] = has_cr[v] & ~ahead;
      end
   end

   assign win = rdy & i_v;

   always_comb begin
      ptr_nxt = ptr;
      sel_d   = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (win[v]) begin
            ptr_nxt = PW'((v + 1) % NUM_VC);
            sel_d   = sel_d | i_d[v*P_W +: P_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < NUM_VC; v++) cnt[v] <= MAX_CR;
         o_credit_err <= '0;
         ptr          <= '0;
      end else begin
         if (|win) ptr <= ptr_nxt;
         for (int v = 0; v < NUM_VC; v++) begin
            case ({win[v], i_vc_credit_gnt[v]})
               2'b10: cnt[v] <= cnt[v] - CW'(1);
               2'b01: begin
                  // A return with nothing outstanding means the receiver lost track.
                  if (cnt[v] == MAX_CR) o_credit_err[v] <= 1'b1;
                  else                  cnt[v] <= cnt[v] + CW'(1);
               end
               default: cnt[v] <= cnt[v];
            endcase
         end
      end
   end

   assign o_b = rst ? '1 : ~rdy;

   generate
      if (REG_OUT != 0) begin : g_reg
         logic [NUM_VC-1:0] tgt_q;
         logic [P_W-1:0]    d_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               tgt_q <= '0;
               d_q   <= '0;
            end else begin
               tgt_q <= win;
               d_q   <= sel_d;
            end
         end
         assign o_vc_target = rst ? '0 : tgt_q;
         assign o_d         = rst ? '0 : d_q;
      end else begin : g_comb
         assign o_vc_target = rst ? '0 : win;
         assign o_d         = rst ? '0 : sel_d;
      end
   endgenerate

endmodule

// File: tb/tb_credit_bp_tx_arb.sv
// Directed bench for credit_bp_tx_arb: a combinational-output and a registered-output
// instance share stimulus; the registered one is expected one cycle behind on the link.
module tb_credit_bp_tx_arb;

   localparam int P_W = 37;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       i_v;
   logic [2*P_W-1:0] i_d;
   logic [1:0]       i_vc_credit_gnt;

   logic [1:0]       c_b, c_tgt, c_err;
   logic [P_W-1:0]   c_d;
   logic [1:0]       r_b, r_tgt, r_err;
   logic [P_W-1:0]   r_d;

   int errors = 0;
   int checks = 0;

   logic [1:0]     prev_tgt = '0;
   logic [P_W-1:0] prev_d   = '0;

   localparam logic [P_W-1:0] PA = {1'b1, 4'h3, 32'h12344321};
   localparam logic [P_W-1:0] PB = {1'b0, 4'h5, 32'hABCD0001};

   credit_bp_tx_arb #(.NUM_VC(2), .D_W(32), .A_W(4), .DEPTH(8), .REG_OUT(0)) dut_c (
      .clk(clk), .rst(rst), .i_v(i_v), .i_d(i_d), .o_b(c_b), .o_vc_target(c_tgt),
      .o_d(c_d), .i_vc_credit_gnt(i_vc_credit_gnt), .o_credit_err(c_err));

   credit_bp_tx_arb #(.NUM_VC(2), .D_W(32), .A_W(4), .DEPTH(8), .REG_OUT(1)) dut_r (
      .clk(clk), .rst(rst), .i_v(i_v), .i_d(i_d), .o_b(r_b), .o_vc_target(r_tgt),
      .o_d(r_d), .i_vc_credit_gnt(i_vc_credit_gnt), .o_credit_err(r_err));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive, check both instances mid-cycle, then advance past the edge.
   task automatic cyc(input string tag, input logic r, input logic [1:0] v,
                      input logic [1:0] g, input logic [1:0] eb, input logic [1:0] et,
                      input logic [P_W-1:0] ed, input logic [1:0] ee);
      logic [1:0]     rt;
      logic [P_W-1:0] rd;
      rst = r; i_v = v; i_vc_credit_gnt = g;
      #4;
      rt = r ? 2'b00 : prev_tgt;
      rd = r ? '0 : prev_d;
      check({tag, "/c_b"},   64'(c_b),   64'(eb));
      check({tag, "/c_tgt"}, 64'(c_tgt), 64'(et));
      check({tag, "/c_d"},   64'(c_d),   64'(ed));
      check({tag, "/c_err"}, 64'(c_err), 64'(ee));
      check({tag, "/r_b"},   64'(r_b),   64'(eb));
      check({tag, "/r_tgt"}, 64'(r_tgt), 64'(rt));
      check({tag, "/r_d"},   64'(r_d),   64'(rd));
      check({tag, "/r_err"}, 64'(r_err), 64'(ee));
      prev_tgt = r ? 2'b00 : et;
      prev_d   = r ? '0 : ed;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag, input int n);
      for (int k = 0; k < n; k++) cyc(tag, 1'b1, 2'b00, 2'b00, 2'b11, 2'b00, '0, 2'b00);
   endtask

   initial begin
      rst = 1'b1; i_v = '0; i_vc_credit_gnt = '0; i_d = {PB, PA};
      @(posedge clk);
      #1;

      // 1: reset, idle VCs both report ready, probe with both requesting
      do_reset("t1_rst", 2);
      cyc("t1_idle", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, '0, 2'b00);
      cyc("t1_idle", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, '0, 2'b00);
      cyc("t1_probe", 1'b0, 2'b11, 2'b00, 2'b10, 2'b01, PA, 2'b00);
      do_reset("t1_rst2", 1);

      // 2: VC0 alone drains its 7 credits, then is backpressured
      for (int k = 0; k < 7; k++)
         cyc("t2_send", 1'b0, 2'b01, 2'b00, (k == 0) ? 2'b10 : 2'b00, 2'b01, PA, 2'b00);
      cyc("t2_empty", 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, '0, 2'b00);
      cyc("t2_empty", 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, '0, 2'b00);
      do_reset("t2_rst", 1);

      // 3: both VCs request, grants alternate, 7 each, then idle
      for (int k = 0; k < 14; k++) begin
         if (k % 2 == 0) cyc("t3_vc0", 1'b0, 2'b11, 2'b00, 2'b10, 2'b01, PA, 2'b00);
         else            cyc("t3_vc1", 1'b0, 2'b11, 2'b00, 2'b01, 2'b10, PB, 2'b00);
      end
      for (int k = 0; k < 3; k++)
         cyc("t3_idle", 1'b0, 2'b11, 2'b00, 2'b11, 2'b00, '0, 2'b00);

      // 4: same-cycle credit does not enable VC0; afterwards spend+grant sustains it
      cyc("t4_nosend", 1'b0, 2'b01, 2'b01, 2'b11, 2'b00, '0, 2'b00);
      for (int k = 0; k < 6; k++)
         cyc("t4_stream", 1'b0, 2'b01, 2'b01, 2'b10, 2'b01, PA, 2'b00);
      cyc("t4_last", 1'b0, 2'b01, 2'b00, 2'b10, 2'b01, PA, 2'b00);
      cyc("t4_empty", 1'b0, 2'b01, 2'b00, 2'b11, 2'b00, '0, 2'b00);
      do_reset("t4_rst", 1);

      // 5: credit returned to a full VC1 raises a sticky error cleared only by reset
      cyc("t5_gnt", 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, '0, 2'b00);
      cyc("t5_sticky", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, '0, 2'b10);
      cyc("t5_sticky", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, '0, 2'b10);
      cyc("t5_rst", 1'b1, 2'b00, 2'b00, 2'b11, 2'b00, '0, 2'b10);
      cyc("t5_rst", 1'b1, 2'b00, 2'b00, 2'b11, 2'b00, '0, 2'b00);
      cyc("t5_clear", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, '0, 2'b00);

      // 6: reset mid-burst with VC0 at 3 credits, then a full 7 again
      for (int k = 0; k < 4; k++)
         cyc("t6_pre", 1'b0, 2'b01, 2'b00, (k == 0) ? 2'b10 : 2'b00, 2'b01, PA, 2'b00);
      cyc("t6_rst", 1'b1, 2'b01, 2'b00, 2'b11, 2'b00, '0, 2'b00);
      for (int k = 0; k < 7; k++)
         cyc("t6_send", 1'b0, 2'b01, 2'b00, (k == 0) ? 2'b10 : 2'b00, 2'b01, PA, 2'b00);
      cyc("t6_empty", 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, '0, 2'b00);
      cyc("t6_idle", 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, '0, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
